// File: rtl/axi_read_slave.sv
// AXI4 read-only slave: one outstanding burst, one memory beat request per data beat.
// Supports FIXED/INCR/WRAP address sequencing; illegal bursts return SLVERR beats.
module axi_read_slave #(
   parameter int unsigned IDW = 12,
   parameter int unsigned AW  = 32,
   parameter int unsigned DW  = 64
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [IDW-1:0] s_axi_arid,
   input  logic [AW-1:0]  s_axi_araddr,
   input  logic [7:0]     s_axi_arlen,
   input  logic [2:0]     s_axi_arsize,
   input  logic [1:0]     s_axi_arburst,
   input  logic           s_axi_arvalid,
   output logic           s_axi_arready,
   output logic [IDW-1:0] s_axi_rid,
   output logic [DW-1:0]  s_axi_rdata,
   output logic [1:0]     s_axi_rresp,
   output logic           s_axi_rlast,
   output logic           s_axi_rvalid,
   input  logic           s_axi_rready,
   input  logic           read_ready,
   output logic           mem_req,
   output logic [AW-1:0]  mem_addr,
   input  logic [DW-1:0]  mem_rdata,
   input  logic           mem_err
);

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DATA} state_t;

   state_t         state, state_next;
   logic [IDW-1:0] id_q;
   logic [AW-1:0]  addr_q;
   logic [7:0]     len_q;
   logic [2:0]     size_q;
   logic [1:0]     burst_q;
   logic [7:0]     cnt_q;
   logic           berr_q;
   logic [DW-1:0]  rdata_q;
   logic [1:0]     rresp_q;

   logic arready_c, mem_req_c, last_c, ar_err_c;

   // Next beat address; WRAP keeps the beat inside the aligned total-size window.
   function automatic logic [AW-1:0] advance(input logic [AW-1:0] addr,
                                             input logic [7:0]    len,
                                             input logic [2:0]    size,
                                             input logic [1:0]    burst);
      logic [AW-1:0] step, mask;
      step = AW'(1) << size;
      mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
      case (burst)
         BURST_FIXED: advance = addr;
         BURST_WRAP:  advance = (addr & ~mask) | ((addr + step) & mask);
         default:     advance = addr + step;
      endcase
   endfunction

   assign ar_err_c = (s_axi_arsize > 3'd3) || (s_axi_arburst == BURST_RSVD) ||
                     ((s_axi_arburst == BURST_WRAP) &&
                      !((s_axi_arlen == 8'd1) || (s_axi_arlen == 8'd3) ||
                        (s_axi_arlen == 8'd7) || (s_axi_arlen == 8'd15)));

   assign last_c = (cnt_q == len_q);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      arready_c  = 1'b0;
      mem_req_c  = 1'b0;
      case (state)
         IDLE: begin
            arready_c = 1'b1;
            if (s_axi_arvalid) state_next = ISSUE;
         end
         ISSUE: begin
            mem_req_c = read_ready && !berr_q;
            if (read_ready || berr_q) state_next = WAIT;
         end
         WAIT: state_next = DATA;
         DATA: begin
            if (s_axi_rready) state_next = last_c ? IDLE : ISSUE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Burst context, beat counter and the registered response beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         id_q    <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
         cnt_q   <= '0;
         berr_q  <= 1'b0;
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else begin
         if (state == IDLE && s_axi_arvalid) begin
            id_q    <= s_axi_arid;
            addr_q  <= s_axi_araddr;
            len_q   <= s_axi_arlen;
            size_q  <= s_axi_arsize;
            burst_q <= s_axi_arburst;
            cnt_q   <= '0;
            berr_q  <= ar_err_c;
         end
         if (state == WAIT) begin
            rdata_q <= berr_q ? '0 : mem_rdata;
            rresp_q <= (berr_q || mem_err) ? RESP_SLVERR : RESP_OKAY;
         end
         if (state == DATA && s_axi_rready && !last_c) begin
            cnt_q  <= cnt_q + 8'd1;
            addr_q <= advance(addr_q, len_q, size_q, burst_q);
         end
      end
   end

   assign s_axi_arready = arready_c && !rst;
   assign mem_req       = mem_req_c && !rst;
   assign mem_addr      = addr_q;
   assign s_axi_rid     = id_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rvalid  = (state == DATA);
   assign s_axi_rlast   = (state == DATA) && last_c;

endmodule

// File: tb/tb_axi_read_slave.sv
// Directed bench for axi_read_slave: burst address sequences, stalls, errors, reset.
module tb_axi_read_slave;
   localparam int unsigned IDW = 12;
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 64;

   logic           clk = 1'b0;
   logic           rst;
   logic [IDW-1:0] arid;
   logic [AW-1:0]  araddr;
   logic [7:0]     arlen;
   logic [2:0]     arsize;
   logic [1:0]     arburst;
   logic           arvalid;
   logic           arready;
   logic [IDW-1:0] rid;
   logic [DW-1:0]  rdata;
   logic [1:0]     rresp;
   logic           rlast;
   logic           rvalid;
   logic           rready;
   logic           read_ready;
   logic           mem_req;
   logic [AW-1:0]  mem_addr;
   logic [DW-1:0]  mem_rdata;
   logic           mem_err;

   logic           err_en;
   logic [AW-1:0]  err_addr;
   logic [AW-1:0]  req_q[$];
   int             n_vec = 0;
   int             n_err = 0;

   axi_read_slave #(.IDW(IDW), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
      .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
      .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata),
      .s_axi_rresp(rresp), .s_axi_rlast(rlast), .s_axi_rvalid(rvalid),
      .s_axi_rready(rready), .read_ready(read_ready), .mem_req(mem_req),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   // Memory: data is a fixed tag plus the requested address, one cycle later.
   always @(posedge clk) begin
      mem_rdata <= {32'hDEAD_0000, mem_addr};
      mem_err   <= mem_req && err_en && (mem_addr == err_addr);
   end

   always @(negedge clk) if (mem_req) req_q.push_back(mem_addr);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send_ar(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
      bit done = 0;
      @(negedge clk);
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
      for (int i = 0; i < 40 && !done; i++) begin
         if (i > 0) @(negedge clk);
         if (arready) begin
            @(posedge clk); #1;
            done = 1;
         end
      end
      arvalid = 1'b0;
      if (!done) check("ar_timeout", 0, 1);
   endtask

   // Returns at a negedge with rvalid high; waits = negedges elapsed.
   task automatic wait_rvalid(output int waits);
      waits = 0;
      do begin
         @(negedge clk);
         waits++;
      end while (!rvalid && waits < 40);
      if (!rvalid) check("rvalid_timeout", 0, 1);
   endtask

   task automatic get_beat(output logic [DW-1:0] d, output logic [1:0] r,
                           output logic l, output logic [IDW-1:0] id, output int waits);
      rready = 1'b1;
      wait_rvalid(waits);
      d = rdata; r = rresp; l = rlast; id = rid;
      @(posedge clk); #1;
   endtask

   logic [DW-1:0]  d, sd;
   logic [1:0]     r, sr;
   logic           l, sl;
   logic [IDW-1:0] id;
   int             w;
   logic [AW-1:0]  exp_a[4];

   initial begin
      rst = 1'b1; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
      arvalid = 1'b0; rready = 1'b1; read_ready = 1'b1; err_en = 1'b0; err_addr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_arready_held", arready, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rst_arready", arready, 1);
      check("rst_rvalid", rvalid, 0);
      check("rst_rlast", rlast, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_rresp", rresp, 0);
      check("rst_rid", rid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_mem_addr", mem_addr, 0);

      // INCR 4 beats of 8 bytes
      req_q.delete();
      send_ar(12'h5A3, 32'h100, 8'd3, 3'd3, 2'b01);
      exp_a = '{32'h100, 32'h108, 32'h110, 32'h118};
      for (int i = 0; i < 4; i++) begin
         get_beat(d, r, l, id, w);
         check($sformatf("incr_data%0d", i), d, {32'hDEAD_0000, exp_a[i]});
         check($sformatf("incr_resp%0d", i), r, 0);
         check($sformatf("incr_last%0d", i), l, (i == 3));
         check($sformatf("incr_id%0d", i), id, 12'h5A3);
         check($sformatf("incr_lat%0d", i), w, 3);
      end
      check("incr_nreq", req_q.size(), 4);
      for (int i = 0; i < 4 && i < req_q.size(); i++)
         check($sformatf("incr_addr%0d", i), req_q[i], exp_a[i]);

      // WRAP 4 beats of 4 bytes starting mid-window
      req_q.delete();
      send_ar(12'h011, 32'h1C, 8'd3, 3'd2, 2'b10);
      exp_a = '{32'h1C, 32'h10, 32'h14, 32'h18};
      for (int i = 0; i < 4; i++) begin
         get_beat(d, r, l, id, w);
         check($sformatf("wrap_data%0d", i), d, {32'hDEAD_0000, exp_a[i]});
         check($sformatf("wrap_last%0d", i), l, (i == 3));
      end
      check("wrap_nreq", req_q.size(), 4);
      for (int i = 0; i < 4 && i < req_q.size(); i++)
         check($sformatf("wrap_addr%0d", i), req_q[i], exp_a[i]);

      // FIXED 3 beats, second beat stalled 5 cycles
      req_q.delete();
      send_ar(12'h022, 32'h40, 8'd2, 3'd3, 2'b00);
      get_beat(d, r, l, id, w);
      check("fix_data0", d, {32'hDEAD_0000, 32'h40});
      rready = 1'b0;
      wait_rvalid(w);
      sd = rdata; sr = rresp; sl = rlast;
      check("fix_data1", sd, {32'hDEAD_0000, 32'h40});
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("fix_stall_rvalid%0d", i), rvalid, 1);
         check($sformatf("fix_stall_data%0d", i), rdata, sd);
         check($sformatf("fix_stall_last%0d", i), {rresp, rlast}, {sr, sl});
         check($sformatf("fix_stall_arready%0d", i), arready, 0);
      end
      check("fix_stall_nreq", req_q.size(), 2);
      rready = 1'b1;
      @(posedge clk); #1;
      get_beat(d, r, l, id, w);
      check("fix_last2", l, 1);
      check("fix_nreq", req_q.size(), 3);
      for (int i = 0; i < 3 && i < req_q.size(); i++)
         check($sformatf("fix_addr%0d", i), req_q[i], 32'h40);

      // Illegal bursts: oversize, bad WRAP length, reserved type
      req_q.delete();
      send_ar(12'h033, 32'h80, 8'd1, 3'd4, 2'b01);
      for (int i = 0; i < 2; i++) begin
         get_beat(d, r, l, id, w);
         check($sformatf("sz_resp%0d", i), r, 2'b10);
         check($sformatf("sz_data%0d", i), d, 0);
         check($sformatf("sz_last%0d", i), l, (i == 1));
      end
      send_ar(12'h034, 32'h90, 8'd2, 3'd2, 2'b10);
      for (int i = 0; i < 3; i++) begin
         get_beat(d, r, l, id, w);
         check($sformatf("wl_resp%0d", i), r, 2'b10);
         check($sformatf("wl_data%0d", i), d, 0);
         check($sformatf("wl_last%0d", i), l, (i == 2));
      end
      send_ar(12'h035, 32'hA0, 8'd0, 3'd2, 2'b11);
      get_beat(d, r, l, id, w);
      check("rsv_resp", r, 2'b10);
      check("rsv_last", l, 1);
      check("err_nreq", req_q.size(), 0);

      // Memory error on the middle beat
      err_en = 1'b1; err_addr = 32'h208;
      send_ar(12'h044, 32'h200, 8'd2, 3'd3, 2'b01);
      for (int i = 0; i < 3; i++) begin
         get_beat(d, r, l, id, w);
         check($sformatf("merr_resp%0d", i), r, (i == 1) ? 2'b10 : 2'b00);
      end
      err_en = 1'b0;

      // Backend not ready holds the request
      req_q.delete();
      read_ready = 1'b0;
      send_ar(12'h055, 32'h500, 8'd0, 3'd3, 2'b01);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("rr_hold_req%0d", i), mem_req, 0);
         check($sformatf("rr_hold_rvalid%0d", i), rvalid, 0);
      end
      read_ready = 1'b1;
      get_beat(d, r, l, id, w);
      check("rr_data", d, {32'hDEAD_0000, 32'h500});
      check("rr_nreq", req_q.size(), 1);

      // Reset while a beat is pending
      send_ar(12'h066, 32'h600, 8'd3, 3'd3, 2'b01);
      rready = 1'b0;
      wait_rvalid(w);
      rst = 1'b1;
      @(negedge clk);
      check("mrst_rvalid", rvalid, 0);
      check("mrst_arready", arready, 0);
      rst = 1'b0;
      @(negedge clk);
      check("mrst_arready_after", arready, 1);
      req_q.delete();
      send_ar(12'h007, 32'h300, 8'd0, 3'd3, 2'b01);
      get_beat(d, r, l, id, w);
      check("mrst_data", d, {32'hDEAD_0000, 32'h300});
      check("mrst_last", l, 1);
      check("mrst_resp", r, 0);
      check("mrst_id", id, 12'h007);
      @(negedge clk);
      check("mrst_idle_rvalid", rvalid, 0);
      check("mrst_idle_arready", arready, 1);
      check("mrst_nreq", req_q.size(), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
